// File: rtl/dac_sched_pkg.sv
// Shared constants for the DAC sample scheduler: FSM encoding, widths and a clog2 helper.
package dac_sched_pkg;

    localparam int unsigned DW_DEF = 16;
    localparam int unsigned OVR_W  = 8;
    localparam int unsigned ST_W   = 2;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_LOAD    = 2'd1;
    localparam logic [1:0] ST_SEND    = 2'd2;
    localparam logic [1:0] ST_RELEASE = 2'd3;

    // Ceiling log2 for sizing index and counter fields (returns 0 for v <= 1).
    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        while ((32'd1 << r) < v) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/dac_sample_sched_rr_arbiter.sv
// Combinational round-robin search: first set request strictly after ptr, wrapping.
module rr_arbiter
    import dac_sched_pkg::*;
#(
    parameter int unsigned NREQ = 4,
    localparam int unsigned CW  = clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [CW-1:0]   ptr,
    output logic [NREQ-1:0] grant,
    output logic [CW-1:0]   idx
);

    int unsigned cand;
    logic        found;

    always_comb begin
        grant = '0;
        idx   = '0;
        found = 1'b0;
        cand  = 0;
        for (int unsigned k = 1; k <= NREQ; k++) begin
            cand = (32'(ptr) + k) % NREQ;
            if (!found && req[CW'(cand)]) begin
                found              = 1'b1;
                grant[CW'(cand)]   = 1'b1;
                idx                = CW'(cand);
            end
        end
    end

endmodule

// File: rtl/dac_sample_sched.sv
// Tick-paced round-robin scheduler sharing one serial DAC between NREQ producers.
// Optional DAC_IDLE_REFRESH_EN: a pending tick with no requester re-sends the last word.
module dac_sample_sched
    import dac_sched_pkg::*;
#(
    parameter int unsigned NREQ    = 4,
    parameter int unsigned DW      = DW_DEF,
    parameter int unsigned RATEDIV = 100,
    localparam int unsigned CW     = clog2(NREQ)
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic [NREQ-1:0]      req,
    input  logic [NREQ*DW-1:0]   reqdata,
    output logic [NREQ-1:0]      ack,
    output logic                 dacdav,
    input  logic                 davdac,
    output logic [DW-1:0]        dacdata,
    output logic [CW-1:0]        chan,
    output logic [OVR_W-1:0]     overrun
);

    localparam int unsigned TW = clog2(RATEDIV);

    logic [ST_W-1:0] state;
    logic [ST_W-1:0] state_nx;
    logic [TW-1:0]   tcnt;
    logic            tickpend;
    logic [CW-1:0]   ptr;
    logic [NREQ-1:0] gnt_c;
    logic [CW-1:0]   gidx_c;
    logic            tick_c;
    logic            load_go_c;
    logic            refresh_go_c;
    logic            send_done_c;
    logic            busy_c;

    rr_arbiter #(.NREQ(NREQ)) u_arb (
        .req   (req),
        .ptr   (ptr),
        .grant (gnt_c),
        .idx   (gidx_c)
    );

    assign tick_c = (tcnt == '0);

    // Next-state and transition strobes.
    always_comb begin
        state_nx     = state;
        load_go_c    = 1'b0;
        refresh_go_c = 1'b0;
        send_done_c  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (tickpend) begin
                    if (|req) begin
                        load_go_c = 1'b1;
                        state_nx  = ST_LOAD;
                    end
`ifdef DAC_IDLE_REFRESH_EN
                    else begin
                        refresh_go_c = 1'b1;
                        state_nx     = ST_SEND;
                    end
`endif
                end
            end
            ST_LOAD: state_nx = ST_SEND;
            ST_SEND: begin
                if (davdac) begin
                    send_done_c = 1'b1;
                    state_nx    = ST_RELEASE;
                end
            end
            ST_RELEASE: begin
                if (!davdac) begin
                    state_nx = ST_IDLE;
                end
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    // A tick in the cycle the handshake completes is not counted as a busy tick.
    assign busy_c = (state != ST_IDLE) && !send_done_c;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Pacing counter, grant latching and DAC-side handshake registers.
    always_ff @(posedge CLK) begin
        if (RST) begin
            tcnt     <= TW'(RATEDIV - 1);
            tickpend <= 1'b0;
            ptr      <= CW'(NREQ - 1);
            ack      <= '0;
            dacdav   <= 1'b0;
            dacdata  <= '0;
            chan     <= '0;
            overrun  <= '0;
        end else begin
            tcnt <= tick_c ? TW'(RATEDIV - 1) : tcnt - TW'(1);
            ack  <= load_go_c ? gnt_c : '0;

            if (load_go_c) begin
                dacdata <= reqdata[32'(gidx_c)*DW +: DW];
                chan    <= gidx_c;
                ptr     <= gidx_c;
            end

            if (load_go_c || refresh_go_c) begin
                dacdav <= 1'b1;
            end else if (send_done_c) begin
                dacdav <= 1'b0;
            end

            if (tick_c) begin
                tickpend <= 1'b1;
            end else if (load_go_c || refresh_go_c) begin
                tickpend <= 1'b0;
            end

            if (tick_c && (tickpend || busy_c) && (overrun != '1)) begin
                overrun <= overrun + OVR_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_dac_sample_sched.sv
// Scoreboard bench for dac_sample_sched: round-robin model, tick timing, overrun and reset.
module tb_dac_sample_sched;

    localparam int NR = 4;
    localparam int W  = 16;
    localparam int R  = 10;

    logic            CLK = 1'b0;
    logic            RST = 1'b1;
    logic [NR-1:0]   req = '0;
    logic [NR*W-1:0] reqdata = '0;
    logic [NR-1:0]   ack;
    logic            dacdav;
    logic            davdac = 1'b0;
    logic [W-1:0]    dacdata;
    logic [1:0]      chan;
    logic [7:0]      overrun;

    always #5 CLK = ~CLK;

    dac_sample_sched #(.NREQ(NR), .DW(W), .RATEDIV(R)) dut (
        .CLK     (CLK),
        .RST     (RST),
        .req     (req),
        .reqdata (reqdata),
        .ack     (ack),
        .dacdav  (dacdav),
        .davdac  (davdac),
        .dacdata (dacdata),
        .chan    (chan),
        .overrun (overrun)
    );

    typedef struct {
        int          ch;
        logic [15:0] word;
    } exp_t;

    exp_t        sb[$];
    exp_t        mon_e;
    int          tests = 0;
    int          fails = 0;
    int          cyc = 0;
    int          rst_cyc = 0;
    int          ack_dly = 3;
    int          rel_dly = 1;
    int          scnt = 0;
    int          mptr = NR - 1;
    logic [15:0] word[NR];
    int          t, tprev, a1, a2, bad, rises;
    bit          prev, ok;
    logic [3:0]  rr;

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    // Reference arbitration: first requester after the last grant, wrapping.
    function automatic int rr_next(input logic [3:0] r, input int p);
        for (int k = 1; k <= NR; k++) begin
            int c;
            c = (p + k) % NR;
            if (r[c]) return c;
        end
        return -1;
    endfunction

    task automatic set_req(input logic [3:0] r);
        exp_t x;
        req = r;
        for (int i = 0; i < NR; i++) reqdata[i*W +: W] = word[i];
        if (r != 0) begin
            mptr   = rr_next(r, mptr);
            x.ch   = mptr;
            x.word = word[mptr];
            sb.push_back(x);
        end
    endtask

    task automatic wait_ack(output int at);
        at = -1;
        for (int n = 0; n < 300; n++) begin
            @(negedge CLK);
            if (ack != 0) begin
                at = cyc;
                return;
            end
        end
        tests++;
        fails++;
        $display("FAIL ack_timeout: no ack within 300 cycles, expected one");
    endtask

    task automatic wait_dav_rise(output bit got);
        bit seen_low;
        seen_low = 1'b0;
        got      = 1'b0;
        for (int n = 0; n < 100; n++) begin
            @(negedge CLK);
            if (!dacdav) seen_low = 1'b1;
            else if (seen_low) begin
                got = 1'b1;
                return;
            end
        end
    endtask

    task automatic do_reset(input int n, input int dly);
        @(negedge CLK);
        RST = 1'b1;
        sb.delete();
        mptr    = NR - 1;
        ack_dly = dly;
        repeat (n) @(negedge CLK);
        RST     = 1'b0;
        rst_cyc = cyc;
    endtask

    // Serializer model: acks ack_dly clocks after dacdav, releases rel_dly clocks after it drops.
    always @(negedge CLK) begin
        if (RST) begin
            davdac = 1'b0;
            scnt   = 0;
        end else if (dacdav && !davdac) begin
            scnt++;
            if (scnt >= ack_dly) begin
                davdac = 1'b1;
                scnt   = 0;
            end
        end else if (!dacdav && davdac) begin
            scnt++;
            if (scnt >= rel_dly) begin
                davdac = 1'b0;
                scnt   = 0;
            end
        end else begin
            scnt = 0;
        end
    end

    // Monitor: every ack pulse is matched against the oldest expected grant.
    always @(negedge CLK) begin
        if (!RST && ack != 0) begin
            if (sb.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_ack: got ack 0x%0h, expected none", ack);
            end else begin
                mon_e = sb.pop_front();
                check("grant_chan", 32'(chan), 32'(mon_e.ch));
                check("grant_ack", 32'(ack), 32'(1) << mon_e.ch);
                check("grant_data", 32'(dacdata), 32'(mon_e.word));
                check("grant_dav", 32'(dacdav), 32'd1);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < NR; i++) word[i] = 16'($urandom);
        do_reset(2, 3);
        check("reset_dacdav", 32'(dacdav), 32'd0);
        check("reset_dacdata", 32'(dacdata), 32'd0);
        check("reset_ack", 32'(ack), 32'd0);
        check("reset_chan", 32'(chan), 32'd0);
        check("reset_overrun", 32'(overrun), 32'd0);

        // Pacing with a single requester.
        set_req(4'b0001);
        for (int i = 0; i < 4; i++) begin
            wait_ack(t);
            if (i == 0) check("first_ack_cycle", 32'(t), 32'(rst_cyc + R + 1));
            else check("ack_period", 32'(t - tprev), 32'(R));
            tprev = t;
            if (i < 3) set_req(4'b0001);
            else begin
                word[0] = 16'h1111; word[1] = 16'h2222;
                word[2] = 16'h3333; word[3] = 16'h4444;
                set_req(4'b1111);
            end
        end
        check("pacing_overrun", 32'(overrun), 32'd0);

        // Full round-robin, then skip-and-wrap from ptr=2 with req=0011.
        for (int i = 0; i < 5; i++) begin
            wait_ack(t);
            if (i < 4) set_req(4'b1111);
            else set_req(4'b0100);
        end
        for (int i = 0; i < 3; i++) begin
            wait_ack(t);
            set_req(4'b0011);
        end

        // Randomized request patterns; only idle or just-granted words may change.
        for (int i = 0; i < 40; i++) begin
            wait_ack(t);
            rr = 4'($urandom_range(1, 15));
            for (int j = 0; j < NR; j++)
                if (!req[j] || j == mptr) word[j] = 16'($urandom);
            set_req(rr);
        end

        // Overrun: serializer stalls 30 clocks, three ticks land while busy.
        do_reset(2, 30);
        word[0] = 16'($urandom);
        set_req(4'b0001);
        wait_ack(a1);
        check("ovr_first_ack", 32'(a1), 32'(rst_cyc + R + 1));
        set_req(4'b0001);
        bad = 0;
        repeat (25) begin
            @(negedge CLK);
            if (!dacdav || ack != 0) bad++;
        end
        check("hold_dav_no_ack", 32'(bad), 32'd0);
        wait_ack(a2);
        check("pending_grant_delay", 32'(a2 - a1), 32'd32);
        check("overrun_count", 32'(overrun), 32'd3);

        // Reset while in SEND.
        repeat (3) @(negedge CLK);
        check("send_dav_high", 32'(dacdav), 32'd1);
        RST = 1'b1;
        @(negedge CLK);
        check("midrst_dacdav", 32'(dacdav), 32'd0);
        check("midrst_dacdata", 32'(dacdata), 32'd0);
        check("midrst_overrun", 32'(overrun), 32'd0);
        sb.delete();
        mptr    = NR - 1;
        ack_dly = 3;
        word[0] = 16'($urandom);
        word[2] = 16'hABCD;
        set_req(4'b0101);
        @(negedge CLK);
        RST     = 1'b0;
        rst_cyc = cyc;
        wait_ack(t);
        check("post_reset_first_ack", 32'(t), 32'(rst_cyc + R + 1));
        set_req(4'b0101);
        wait_ack(t);
        set_req(4'b0000);

`ifdef DAC_IDLE_REFRESH_EN
        for (int i = 0; i < 2; i++) begin
            wait_dav_rise(ok);
            check("refresh_rise", 32'(ok), 32'd1);
            check("refresh_data", 32'(dacdata), 32'hABCD);
            check("refresh_chan", 32'(chan), 32'd2);
        end
`else
        rises = 0;
        prev  = dacdav;
        repeat (3 * R) begin
            @(negedge CLK);
            if (dacdav && !prev) rises++;
            prev = dacdav;
        end
        check("idle_no_send", 32'(rises), 32'd0);
        check("idle_ack_zero", 32'(ack), 32'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
